hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
- Control-side counterpart of the 5-stage pipelined datapath.
- Decodes the instruction held in IF/ID and keeps its own shadow pipeline of destination info for EX and MEM.
- Drives the datapath's four forwarding selects.
- Detects load-use hazards and drives a one-cycle stall/bubble, with a saturating stall counter for performance checks.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  system clock, posedge.
- rst  in  1  asynchronous, active-low reset.
- id_instr  in  32  instruction currently in IF/ID (decode stage).
- flush  in  1  kill the instruction in ID this cycle (taken branch/jump).
- ex_forward_a  out  1  select ALU result for operand A into ID/EX.
- ex_forward_b  out  1  select ALU result for operand B into ID/EX.
- mem_forward_a  out  1  select MEM-stage Dw for operand A.
- mem_forward_b  out  1  select MEM-stage Dw for operand B.
- stall  out  1  hold PC and IF/ID this cycle.
- bubble  out  1  zero RegWr/MemWr entering ID/EX this cycle.
- stall_count  out  CNT_W  total load-use stall cycles, saturating.

Behaviour:
Decode of id_instr (combinational):
- op=0x00 R-type: dest=rd, writes=1, uses rs and rt.
- op=0x00 with funct=0x08 (jr): writes=0, uses rs.
- op=0x08 addi: dest=rt, writes=1, uses rs.
- op=0x23 lw: dest=rt, writes=1, is_load=1, uses rs.
- op=0x2B sw: writes=0, uses rs and rt.
- op=0x04 beq: writes=0, uses rs and rt.
- op=0x02 j: writes=0, uses nothing.
- Any other opcode: writes=0, uses nothing.
- dest=0 forces writes=0; register $0 is never forwarded.

Shadow slots:
- Each slot holds {valid, dest, writes, is_load}; there is one EX slot and one MEM slot.
- Every posedge: MEM slot <= EX slot.
- EX slot <= decoded id_instr, or invalid if flush or bubble is asserted.

Forward selects (combinational, same cycle as id_instr):
- ex_fwd_x = EX valid & writes & dest==src_x & src_x used & !is_load.
- mem_fwd_x = MEM valid & writes & dest==src_x & src_x used & !ex_fwd_x. EX has priority; mem_fwd is deasserted whenever ex_fwd matches.
- All four selects are 0 while stall=1.

Load-use hazard:
- ld_hz = EX valid & is_load & dest matches a used ID source & !flush.
- stall = bubble = ld_hz while the FSM is in RUN.

FSM, states RUN and LD_STALL:
- RUN -> LD_STALL when ld_hz.
- LD_STALL -> RUN unconditionally after one cycle.
- In LD_STALL, stall=0. The load is now in the MEM slot, so mem_fwd resolves the dependency.

Counter:
- stall_count increments on each cycle with stall=1.
- It saturates at all-ones.

Boundaries:
- flush and ld_hz in the same cycle: flush wins; no stall, no count.
- Back-to-back loads: each dependency stalls at most one cycle.
- rst low (asynchronous, any time): both slots invalid, FSM=RUN, stall_count=0, and all outputs 0 immediately.
- First posedge after reset release: normal operation.
- Latency: forward selects and stall are combinational from id_instr plus registered slots; slots and FSM update with 1-cycle latency.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - opcode and funct constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, FN_JR);
  - typedef slot_t {valid, dest[REG_AW], writes, is_load};
  - typedef enum state_t {RUN, LD_STALL}.
- One sub-module: instr_dest_decode, a pure combinational block from instruction to {slot_t, rs, rt, use_rs, use_rt}.

Test Plan:
- Reset: rst=0 mid-run with a pending load in EX -> all outputs 0 at once; stall_count=0; after release, nop 0x00000000 yields no forwards.
- EX forward: 0x00221820 (add $3,$1,$2), then 0x00642822 (sub $5,$3,$4) -> ex_forward_a=1, others 0.
- MEM forward: add $3 as above, nop, then sub $5,$3,$4 -> mem_forward_a=1, ex_forward_a=0.
- Load-use: 0x8C220000 (lw $2,0($1)), then 0x00422020 (add $4,$2,$2) -> stall=bubble=1 for exactly one cycle with forwards 0; next cycle mem_forward_a=mem_forward_b=1; stall_count=1.
- $0 and flush: 0x20200005 (addi $0,$1,5) then a reader of $0 -> no forwards. Separately, lw $2 with flush=1 while add $4,$2,$2 is in ID -> stall=0.
- Counter: hold id_instr at add $4,$2,$2 after each of 2^CNT_W+2 loads -> stall_count stops at 0xFFFF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode constants, shadow-slot record and FSM states for the pipeline
// control path.
package pipe_ctrl_pkg;

  localparam int SLOT_AW = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef struct packed {
    logic               valid;
    logic [SLOT_AW-1:0] dest;
    logic               writes;
    logic               is_load;
  } slot_t;

  typedef enum logic {
    RUN      = 1'b0,
    LD_STALL = 1'b1
  } state_t;

endpackage

// File: rtl/instr_dest_decode.sv
// Combinational decode of one instruction into its destination slot and the
// source registers it reads.
module instr_dest_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [31:0]        instr,
  output slot_t              slot,
  output logic [SLOT_AW-1:0] rs,
  output logic [SLOT_AW-1:0] rt,
  output logic               use_rs,
  output logic               use_rt
);

  logic [5:0]         op;
  logic [5:0]         funct;
  logic [SLOT_AW-1:0] rd;

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];

  always_comb begin
    slot       = '0;
    slot.valid = 1'b1;
    use_rs     = 1'b0;
    use_rt     = 1'b0;
    case (op)
      OP_RTYPE: begin
        use_rs = 1'b1;
        if (funct == FN_JR) begin
          slot.writes = 1'b0;
        end else begin
          use_rt      = 1'b1;
          slot.dest   = rd;
          slot.writes = 1'b1;
        end
      end
      OP_ADDI: begin
        use_rs      = 1'b1;
        slot.dest   = rt;
        slot.writes = 1'b1;
      end
      OP_LW: begin
        use_rs       = 1'b1;
        slot.dest    = rt;
        slot.writes  = 1'b1;
        slot.is_load = 1'b1;
      end
      OP_SW, OP_BEQ: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_J: begin
        slot.writes = 1'b0;
      end
      default: begin
        slot.writes = 1'b0;
      end
    endcase
    // $0 is never a real destination; a load to $0 also cannot cause a hazard
    if (slot.dest == '0) begin
      slot.writes  = 1'b0;
      slot.is_load = 1'b0;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Control-side forwarding and load-use stall logic for the 5-stage pipeline,
// tracking EX/MEM destinations in a private shadow pipeline.
module hazard_forward_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_instr,
  input  logic             flush,
  output logic             ex_forward_a,
  output logic             ex_forward_b,
  output logic             mem_forward_a,
  output logic             mem_forward_b,
  output logic             stall,
  output logic             bubble,
  output logic [CNT_W-1:0] stall_count
);

  slot_t             id_slot;
  slot_t             ex_slot;
  slot_t             mem_slot;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic              use_rs;
  logic              use_rt;
  state_t            state;
  state_t            state_nxt;

  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic ex_sel_a, ex_sel_b;
  logic ld_hz;

  instr_dest_decode u_decode (
    .instr  (id_instr),
    .slot   (id_slot),
    .rs     (rs),
    .rt     (rt),
    .use_rs (use_rs),
    .use_rt (use_rt)
  );

  assign ex_hit_a  = ex_slot.valid  & ex_slot.writes  & use_rs & (ex_slot.dest  == rs);
  assign ex_hit_b  = ex_slot.valid  & ex_slot.writes  & use_rt & (ex_slot.dest  == rt);
  assign mem_hit_a = mem_slot.valid & mem_slot.writes & use_rs & (mem_slot.dest == rs);
  assign mem_hit_b = mem_slot.valid & mem_slot.writes & use_rt & (mem_slot.dest == rt);

  // A load in EX has no ALU result to forward; it is covered by the stall path
  assign ex_sel_a = ex_hit_a & ~ex_slot.is_load;
  assign ex_sel_b = ex_hit_b & ~ex_slot.is_load;

  assign ld_hz = ex_slot.is_load & (ex_hit_a | ex_hit_b) & ~flush;

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      RUN: begin
        if (ld_hz) begin
          stall     = 1'b1;
          state_nxt = LD_STALL;
        end
      end
      LD_STALL: state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  assign bubble        = stall;
  assign ex_forward_a  = ex_sel_a & ~stall;
  assign ex_forward_b  = ex_sel_b & ~stall;
  assign mem_forward_a = mem_hit_a & ~ex_sel_a & ~stall;
  assign mem_forward_b = mem_hit_b & ~ex_sel_b & ~stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_slot     <= '0;
      mem_slot    <= '0;
      state       <= RUN;
      stall_count <= '0;
    end else begin
      mem_slot <= ex_slot;
      ex_slot  <= (flush || bubble) ? slot_t'('0) : id_slot;
      state    <= state_nxt;
      if (stall && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed self-checking bench for hazard_forward_unit; the counter is
// narrowed so saturation is reachable in a short run.
module tb_hazard_forward_unit;

  localparam int TB_CNT_W = 8;

  localparam logic [31:0] NOP   = 32'h00000000;
  localparam logic [31:0] ADD3  = 32'h00221820; // add $3,$1,$2
  localparam logic [31:0] SUB5  = 32'h00642822; // sub $5,$3,$4
  localparam logic [31:0] LW2   = 32'h8C220000; // lw  $2,0($1)
  localparam logic [31:0] ADD4  = 32'h00422020; // add $4,$2,$2
  localparam logic [31:0] ADDI0 = 32'h20200005; // addi $0,$1,5
  localparam logic [31:0] RD0   = 32'h00002820; // add $5,$0,$0
  localparam logic [31:0] LW3   = 32'h8C430000; // lw  $3,0($2)
  localparam logic [31:0] ADD43 = 32'h00632020; // add $4,$3,$3

  logic                clk;
  logic                rst;
  logic [31:0]         id_instr;
  logic                flush;
  logic                ex_forward_a, ex_forward_b, mem_forward_a, mem_forward_b;
  logic                stall, bubble;
  logic [TB_CNT_W-1:0] stall_count;
  logic [5:0]          vec;

  int tests = 0;
  int fails = 0;

  hazard_forward_unit #(.REG_AW(5), .CNT_W(TB_CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_instr      (id_instr),
    .flush         (flush),
    .ex_forward_a  (ex_forward_a),
    .ex_forward_b  (ex_forward_b),
    .mem_forward_a (mem_forward_a),
    .mem_forward_b (mem_forward_b),
    .stall         (stall),
    .bubble        (bubble),
    .stall_count   (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ex_a, ex_b, mem_a, mem_b, stall, bubble}
  assign vec = {ex_forward_a, ex_forward_b, mem_forward_a, mem_forward_b, stall, bubble};

  task automatic drive(input logic [31:0] instr, input logic fl);
    @(posedge clk);
    #1;
    id_instr = instr;
    flush    = fl;
    @(negedge clk);
  endtask

  task automatic flush_pipe();
    drive(NOP, 1'b0);
    drive(NOP, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0; id_instr = NOP; flush = 1'b0;
    #2;
    tests++;
    if (vec !== 6'b000000) begin fails++; $display("FAIL reset_outputs got %b exp 000000", vec); end
    tests++;
    if (stall_count !== '0) begin fails++; $display("FAIL reset_count got %0d exp 0", stall_count); end
    #20 rst = 1'b1;
    drive(NOP, 1'b0);
    drive(NOP, 1'b0);
    tests++;
    if (vec !== 6'b000000) begin fails++; $display("FAIL reset_nop got %b exp 000000", vec); end
  endtask

  task automatic test_ex_forward();
    flush_pipe();
    drive(ADD3, 1'b0);
    drive(SUB5, 1'b0);
    tests++;
    if (vec !== 6'b100000) begin fails++; $display("FAIL ex_fwd got %b exp 100000", vec); end
    // newer writer in EX beats older writer of the same register in MEM
    flush_pipe();
    drive(ADD3, 1'b0);
    drive(ADD3, 1'b0);
    drive(SUB5, 1'b0);
    tests++;
    if (vec !== 6'b100000) begin fails++; $display("FAIL ex_priority got %b exp 100000", vec); end
  endtask

  task automatic test_mem_forward();
    flush_pipe();
    drive(ADD3, 1'b0);
    drive(NOP, 1'b0);
    drive(SUB5, 1'b0);
    tests++;
    if (vec !== 6'b001000) begin fails++; $display("FAIL mem_fwd got %b exp 001000", vec); end
  endtask

  task automatic test_load_use();
    logic [TB_CNT_W-1:0] c0;
    flush_pipe();
    c0 = stall_count;
    drive(LW2, 1'b0);
    drive(ADD4, 1'b0);
    tests++;
    if (vec !== 6'b000011) begin fails++; $display("FAIL ld_stall got %b exp 000011", vec); end
    drive(ADD4, 1'b0);
    tests++;
    if (vec !== 6'b001100) begin fails++; $display("FAIL ld_mem_fwd got %b exp 001100", vec); end
    tests++;
    if (stall_count !== c0 + 1'b1) begin fails++; $display("FAIL ld_count got %0d exp %0d", stall_count, c0 + 1'b1); end
    drive(ADD4, 1'b0);
    tests++;
    if (vec !== 6'b000000) begin fails++; $display("FAIL ld_one_cycle got %b exp 000000", vec); end
  endtask

  task automatic test_zero_and_flush();
    logic [TB_CNT_W-1:0] c0;
    flush_pipe();
    drive(ADDI0, 1'b0);
    drive(RD0, 1'b0);
    tests++;
    if (vec !== 6'b000000) begin fails++; $display("FAIL zero_ex got %b exp 000000", vec); end
    drive(RD0, 1'b0);
    tests++;
    if (vec !== 6'b000000) begin fails++; $display("FAIL zero_mem got %b exp 000000", vec); end
    flush_pipe();
    c0 = stall_count;
    drive(LW2, 1'b0);
    drive(ADD4, 1'b1);
    tests++;
    if (vec !== 6'b000000) begin fails++; $display("FAIL flush_nostall got %b exp 000000", vec); end
    drive(ADD4, 1'b0);
    tests++;
    if (vec !== 6'b001100) begin fails++; $display("FAIL flush_after got %b exp 001100", vec); end
    tests++;
    if (stall_count !== c0) begin fails++; $display("FAIL flush_count got %0d exp %0d", stall_count, c0); end
  endtask

  task automatic test_back_to_back();
    logic [TB_CNT_W-1:0] c0;
    flush_pipe();
    c0 = stall_count;
    drive(LW2, 1'b0);
    drive(LW3, 1'b0);
    tests++;
    if (vec !== 6'b000011) begin fails++; $display("FAIL b2b_stall1 got %b exp 000011", vec); end
    drive(LW3, 1'b0);
    tests++;
    if (vec !== 6'b001000) begin fails++; $display("FAIL b2b_fwd1 got %b exp 001000", vec); end
    drive(ADD43, 1'b0);
    tests++;
    if (vec !== 6'b000011) begin fails++; $display("FAIL b2b_stall2 got %b exp 000011", vec); end
    drive(ADD43, 1'b0);
    tests++;
    if (vec !== 6'b001100) begin fails++; $display("FAIL b2b_fwd2 got %b exp 001100", vec); end
    tests++;
    if (stall_count !== c0 + 2'd2) begin fails++; $display("FAIL b2b_count got %0d exp %0d", stall_count, c0 + 2'd2); end
  endtask

  task automatic test_reset_midrun();
    flush_pipe();
    drive(LW2, 1'b0);
    drive(ADD4, 1'b0);
    tests++;
    if (stall !== 1'b1) begin fails++; $display("FAIL mid_prestall got %b exp 1", stall); end
    #1 rst = 1'b0;
    #1;
    tests++;
    if (vec !== 6'b000000) begin fails++; $display("FAIL mid_reset_outputs got %b exp 000000", vec); end
    tests++;
    if (stall_count !== '0) begin fails++; $display("FAIL mid_reset_count got %0d exp 0", stall_count); end
    #1 rst = 1'b1;
    drive(NOP, 1'b0);
    tests++;
    if (vec !== 6'b000000) begin fails++; $display("FAIL mid_release_nop got %b exp 000000", vec); end
  endtask

  task automatic test_counter();
    for (int i = 0; i < (1 << TB_CNT_W) + 2; i++) begin
      drive(LW2, 1'b0);
      drive(ADD4, 1'b0);
      if (i == 9) begin
        tests++;
        if (stall_count !== 8'd9) begin fails++; $display("FAIL cnt_progress got %0d exp 9", stall_count); end
      end
    end
    drive(NOP, 1'b0);
    tests++;
    if (stall_count !== '1) begin fails++; $display("FAIL cnt_saturate got %0d exp %0d", stall_count, {TB_CNT_W{1'b1}}); end
  endtask

  initial begin
    test_reset();
    test_ex_forward();
    test_mem_forward();
    test_load_use();
    test_zero_and_flush();
    test_back_to_back();
    test_reset_midrun();
    test_counter();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
